// File: rtl/approx_mac_pkg.sv
// rtl/approx_mac_pkg.sv - shared types and constants for the approximate MAC accumulator
package approx_mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int ACC_W_DEF     = 40;
  localparam int MAX_TERMS_DEF = 256;

  // Clamp limits for a w-bit signed accumulator; w must not exceed 64.
  function automatic logic signed [63:0] sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/approx_mac_acc_sat_add.sv
// rtl/approx_mac_acc_sat_add.sv - W-bit signed adder with overflow detect
// Clamps to the signed limits on overflow when ACC_SAT_EN is defined, wraps otherwise.
module sat_add
  import approx_mac_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ACC_SAT_EN
  localparam logic [W-1:0] HI = W'(sat_hi(W));
  localparam logic [W-1:0] LO = W'(sat_lo(W));

  // Overflow direction follows the operands' common sign.
  assign sum = ovf ? (a[W-1] ? LO : HI) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/approx_mac_acc.sv
// rtl/approx_mac_acc.sv - streaming signed frame accumulator behind the approximate multiplier
// Optional saturation via ACC_SAT_EN (see sat_add).
module approx_mac_acc
  import approx_mac_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_trunc
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;

  logic               accept;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   next_sum;
  logic               add_ovf;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic               hit_max;
  logic               close;

  // A pending result blocks input only while the consumer is not taking it.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  assign base     = (state == IDLE) ? '0 : acc;
  assign p_ext    = {{(ACC_W-32){in_p[31]}}, in_p};
  assign cnt_next = ((state == IDLE) ? '0 : cnt) + CNT_W'(1);
  assign ovf_next = ((state == ACCUM) & ovf_sticky) | add_ovf;
  assign hit_max  = (cnt_next == CNT_W'(MAX_TERMS));
  assign close    = in_last | hit_max;

  sat_add #(.W(ACC_W)) u_add (
    .a   (base),
    .b   (p_ext),
    .sum (next_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_cnt    <= '0;
      out_ovf    <= 1'b0;
      out_trunc  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (close) begin
          // A close in the same cycle as a consume overrides the clear above.
          out_sum   <= next_sum;
          out_cnt   <= cnt_next;
          out_ovf   <= ovf_next;
          out_trunc <= hit_max & ~in_last;
          out_valid <= 1'b1;
          state     <= IDLE;
        end else begin
          acc        <= next_sum;
          cnt        <= cnt_next;
          ovf_sticky <= ovf_next;
          state      <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mac_acc.sv
// tb/tb_approx_mac_acc.sv - scoreboard bench for approx_mac_acc (honours ACC_SAT_EN)
module tb_approx_mac_acc;

  localparam int ACC_W     = 33;
  localparam int MAX_TERMS = 4;
  localparam int CNT_W     = $clog2(MAX_TERMS + 1);

  localparam longint HI  = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint LO  = -(64'sd1 <<< (ACC_W - 1));
  localparam longint MOD = 64'sd1 <<< ACC_W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  logic             out_trunc;

  approx_mac_acc #(.ACC_W(ACC_W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             trunc;
  } res_t;

  res_t   exp_q[$];
  res_t   exp_r;
  res_t   got_r;
  int     checks = 0;
  int     errors = 0;

  longint m_sum;
  int     m_cnt;
  bit     m_ovf;
  bit     directed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input longint sum, input int cnt, input bit ovf, input bit trunc);
    res_t r;
    r.sum   = sum[ACC_W-1:0];
    r.cnt   = cnt[CNT_W-1:0];
    r.ovf   = ovf;
    r.trunc = trunc;
    exp_q.push_back(r);
  endtask

  // Reference: exact integer sum per beat, out-of-range means overflow, then clamp or wrap.
  task automatic model_beat(input logic [31:0] p, input bit last);
    longint s;
    s = m_sum + longint'($signed(p));
    if (s > HI || s < LO) begin
      m_ovf = 1'b1;
`ifdef ACC_SAT_EN
      s = (s > HI) ? HI : LO;
`else
      s = (s > HI) ? s - MOD : s + MOD;
`endif
    end
    m_sum = s;
    m_cnt++;
    if (last || m_cnt == MAX_TERMS) begin
      if (!directed) push_exp(m_sum, m_cnt, m_ovf, !last);
      m_sum = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  // rdy: 0/1 fixed out_ready, 2 random out_ready.
  task automatic beat(input logic [31:0] p, input bit last, input int rdy);
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_p      = p;
      in_last   = last;
      out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
      #1;
      if (in_ready) begin
        model_beat(p, last);
        done = 1'b1;
      end else if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat not accepted within 50 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int rdy);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (chk) begin
      check("reset_out_valid", out_valid, 0);
      check("reset_out_sum",   out_sum,   0);
      check("reset_out_cnt",   out_cnt,   0);
      check("reset_out_ovf",   out_ovf,   0);
      check("reset_out_trunc", out_trunc, 0);
      check("reset_in_ready",  in_ready,  1);
    end
  endtask

  // Monitor: a result is consumed at the edge where out_valid & out_ready hold.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checks++;
        got_r = {out_sum, out_cnt, out_ovf, out_trunc};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: sum=%0h cnt=%0d with no expected entry", out_sum, out_cnt);
        end else begin
          exp_r = exp_q.pop_front();
          if (got_r !== exp_r) begin
            errors++;
            $display("FAIL result: got sum=%0h cnt=%0d ovf=%0b trunc=%0b, expected sum=%0h cnt=%0d ovf=%0b trunc=%0b",
                     got_r.sum, got_r.cnt, got_r.ovf, got_r.trunc,
                     exp_r.sum, exp_r.cnt, exp_r.ovf, exp_r.trunc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b0;
    directed = 1'b1;
    do_reset(1'b1);

    // Basic frame
    beat(32'd100, 1'b0, 1); beat(-32'sd30, 1'b0, 1); beat(32'd5, 1'b1, 1);
    push_exp(75, 3, 1'b0, 1'b0);
    idle(1);

    // Single-beat frames back to back
    beat(32'hFFFF_FFFF, 1'b1, 1);
    push_exp(-1, 1, 1'b0, 1'b0);
    directed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      beat($urandom, 1'b1, 1);
      check("b2b_out_valid", out_valid, 1);
    end
    idle(1);
    directed = 1'b1;

    // Backpressure
    idle(1);
    beat(32'd11, 1'b1, 0);
    push_exp(11, 1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_p = 32'd9; in_last = 1'b1; out_ready = 1'b0;
      #1;
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_sum",   out_sum,   11);
    end
    beat(32'd9, 1'b1, 1);
    push_exp(9, 1, 1'b0, 1'b0);
    idle(1);

    // Overflow
    for (int i = 0; i < 3; i++) beat(32'h7FFF_FFFF, i == 2, 1);
`ifdef ACC_SAT_EN
    push_exp(64'sd4294967295, 3, 1'b1, 1'b0);
`else
    push_exp(-64'sd2147483651, 3, 1'b1, 1'b0);
`endif
    idle(1);

    // Reset mid-frame
    beat(32'd50, 1'b0, 1); beat(32'd60, 1'b0, 1);
    do_reset(1'b0);
    beat(32'd7, 1'b1, 1);
    push_exp(7, 1, 1'b0, 1'b0);
    idle(1);

    // Truncation at MAX_TERMS, fifth beat opens the next frame
    for (int i = 0; i < 5; i++) begin
      beat(32'd1, 1'b0, 1);
      if (i == 3) push_exp(4, 4, 1'b0, 1'b1);
    end
    beat(32'd2, 1'b1, 1);
    push_exp(3, 2, 1'b0, 1'b0);
    idle(1);

    // Randomised traffic
    directed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle(2);
      end else begin
        v = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
        beat(v, $urandom_range(0, 2) == 0, 2);
      end
    end
    repeat (5) idle(1);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
